// File: rtl/ex_stage_md_if.sv
// Execute-stage bundle: ID/EX operands and controls in, EX/MEM and hazard-unit signals out.
// Ov_E is present only when EX_OVERFLOW_EN is defined.
interface ex_stage_md_if #(
  parameter int unsigned WIDTH = 32
);
  logic [31:0]      instr_E;
  logic [WIDTH-1:0] RD1;
  logic [WIDTH-1:0] RD2;
  logic [WIDTH-1:0] ResultW;
  logic [WIDTH-1:0] ALU_O_M;
  logic [1:0]       ForwardA_E;
  logic [1:0]       ForwardB_E;
  logic [4:0]       Rs_E;
  logic [4:0]       Rt_E;
  logic [4:0]       Rd_E;
  logic [WIDTH-1:0] extimm;
  logic [1:0]       RegDst_E;
  logic             ALUSrc_E;
  logic [2:0]       ALUOp_E;
  logic [2:0]       MDOp_E;
  logic [1:0]       HiLoRead_E;
  logic [WIDTH-1:0] ALUOut;
  logic [WIDTH-1:0] WriteData_E;
  logic [4:0]       WriteReg_E;
  logic [4:0]       Rs_Hazard;
  logic [4:0]       Rt_Hazard;
  logic             Busy;
  logic             Stall_MD;
`ifdef EX_OVERFLOW_EN
  logic             Ov_E;
`endif

  modport master (
    output instr_E, RD1, RD2, ResultW, ALU_O_M, ForwardA_E, ForwardB_E,
    output Rs_E, Rt_E, Rd_E, extimm, RegDst_E, ALUSrc_E, ALUOp_E, MDOp_E, HiLoRead_E,
    input  ALUOut, WriteData_E, WriteReg_E, Rs_Hazard, Rt_Hazard, Busy, Stall_MD
`ifdef EX_OVERFLOW_EN
    , input Ov_E
`endif
  );

  modport slave (
    input  instr_E, RD1, RD2, ResultW, ALU_O_M, ForwardA_E, ForwardB_E,
    input  Rs_E, Rt_E, Rd_E, extimm, RegDst_E, ALUSrc_E, ALUOp_E, MDOp_E, HiLoRead_E,
    output ALUOut, WriteData_E, WriteReg_E, Rs_Hazard, Rt_Hazard, Busy, Stall_MD
`ifdef EX_OVERFLOW_EN
    , output Ov_E
`endif
  );
endinterface

// File: rtl/ex_stage_md.sv
// Execute stage: forwarding, ALU, RegDst select, iterative mult/div with HI/LO.
// Define EX_OVERFLOW_EN to add the Ov_E signed add/sub overflow output.
module ex_stage_md #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 32
) (
  input logic         clk,
  input logic         reset,
  ex_stage_md_if.slave bus
);
  localparam int unsigned SHW  = $clog2(WIDTH);
  localparam int unsigned MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNTW = $clog2(MAXC + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SLT
  } alu_op_e;

  typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} md_kind_e;

  logic [WIDTH-1:0] src_a, fwd_b, src_b, alu_res;
  logic [31:0]      shamt_ext;
  logic [SHW-1:0]   shamt;

  always_comb begin
    unique case (bus.ForwardA_E)
      2'b01:   src_a = bus.ResultW;
      2'b10:   src_a = bus.ALU_O_M;
      default: src_a = bus.RD1;
    endcase
    unique case (bus.ForwardB_E)
      2'b01:   fwd_b = bus.ResultW;
      2'b10:   fwd_b = bus.ALU_O_M;
      default: fwd_b = bus.RD2;
    endcase
  end

  assign src_b     = bus.ALUSrc_E ? bus.extimm : fwd_b;
  assign shamt_ext = {27'd0, bus.instr_E[10:6]};
  assign shamt     = shamt_ext[SHW-1:0];

  // Shifts operate on the B operand (rt), matching the MIPS sll/srl form.
  always_comb begin
    unique case (alu_op_e'(bus.ALUOp_E))
      ALU_ADD: alu_res = src_a + src_b;
      ALU_SUB: alu_res = src_a - src_b;
      ALU_AND: alu_res = src_a & src_b;
      ALU_OR:  alu_res = src_a | src_b;
      ALU_XOR: alu_res = src_a ^ src_b;
      ALU_SLL: alu_res = src_b << shamt;
      ALU_SRL: alu_res = src_b >> shamt;
      ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    unique case (bus.RegDst_E)
      2'b01:   bus.WriteReg_E = bus.Rd_E;
      2'b10:   bus.WriteReg_E = 5'd31;
      default: bus.WriteReg_E = bus.Rt_E;
    endcase
  end

  assign bus.WriteData_E = fwd_b;
  assign bus.Rs_Hazard   = bus.Rs_E;
  assign bus.Rt_Hazard   = bus.Rt_E;

  logic             busy_q, busy_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  md_kind_e         kind_q, kind_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] md_hi, md_lo;
  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic             md_start, hilo_sel;

  assign md_start = (bus.MDOp_E >= 3'd1) && (bus.MDOp_E <= 3'd4) && !busy_q;
  assign hilo_sel = (bus.HiLoRead_E == 2'b01) || (bus.HiLoRead_E == 2'b10);

  assign prod_s = $signed({{WIDTH{opa_q[WIDTH-1]}}, opa_q}) *
                  $signed({{WIDTH{opb_q[WIDTH-1]}}, opb_q});
  assign prod_u = {{WIDTH{1'b0}}, opa_q} * {{WIDTH{1'b0}}, opb_q};

  // Divide-by-zero and MIN/-1 are resolved explicitly so the divider never sees them.
  always_comb begin
    md_hi = '0;
    md_lo = '0;
    unique case (kind_q)
      MD_MULT:  {md_hi, md_lo} = prod_s;
      MD_MULTU: {md_hi, md_lo} = prod_u;
      MD_DIV: begin
        if (opb_q == '0) begin
          md_lo = '1;
          md_hi = opa_q;
        end else if (opa_q == MIN_NEG && opb_q == '1) begin
          md_lo = MIN_NEG;
          md_hi = '0;
        end else begin
          md_lo = WIDTH'($signed(opa_q) / $signed(opb_q));
          md_hi = WIDTH'($signed(opa_q) % $signed(opb_q));
        end
      end
      MD_DIVU: begin
        if (opb_q == '0) begin
          md_lo = '1;
          md_hi = opa_q;
        end else begin
          md_lo = opa_q / opb_q;
          md_hi = opa_q % opb_q;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    kind_d = kind_q;
    opa_d  = opa_q;
    opb_d  = opb_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    if (busy_q) begin
      if (cnt_q == CNTW'(1)) begin
        busy_d = 1'b0;
        cnt_d  = '0;
        hi_d   = md_hi;
        lo_d   = md_lo;
      end else begin
        cnt_d = cnt_q - CNTW'(1);
      end
    end else if (md_start) begin
      busy_d = 1'b1;
      opa_d  = src_a;
      opb_d  = fwd_b;
      unique case (bus.MDOp_E)
        3'd1:    begin kind_d = MD_MULT;  cnt_d = CNTW'(MUL_CYCLES); end
        3'd2:    begin kind_d = MD_MULTU; cnt_d = CNTW'(MUL_CYCLES); end
        3'd3:    begin kind_d = MD_DIV;   cnt_d = CNTW'(DIV_CYCLES); end
        default: begin kind_d = MD_DIVU;  cnt_d = CNTW'(DIV_CYCLES); end
      endcase
    end else if (bus.MDOp_E == 3'd5) begin
      hi_d = src_a;
    end else if (bus.MDOp_E == 3'd6) begin
      lo_d = src_a;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      kind_q <= MD_MULT;
      opa_q  <= '0;
      opb_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      kind_q <= kind_d;
      opa_q  <= opa_d;
      opb_q  <= opb_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  always_comb begin
    unique case (bus.HiLoRead_E)
      2'b01:   bus.ALUOut = hi_q;
      2'b10:   bus.ALUOut = lo_q;
      default: bus.ALUOut = alu_res;
    endcase
  end

  assign bus.Busy     = busy_q;
  assign bus.Stall_MD = busy_q &&
                        (((bus.MDOp_E >= 3'd1) && (bus.MDOp_E <= 3'd6)) || hilo_sel);

`ifdef EX_OVERFLOW_EN
  always_comb begin
    bus.Ov_E = 1'b0;
    if (!hilo_sel) begin
      if (bus.ALUOp_E == 3'd0)
        bus.Ov_E = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (alu_res[WIDTH-1] != src_a[WIDTH-1]);
      else if (bus.ALUOp_E == 3'd1)
        bus.Ov_E = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (alu_res[WIDTH-1] != src_a[WIDTH-1]);
    end
  end
`endif
endmodule

// File: tb/tb_ex_stage_md.sv
// Bench for ex_stage_md: table of combinational vectors plus mult/div scoreboard sequences.
module tb_ex_stage_md;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  ex_stage_md_if #(.WIDTH(32)) bus ();

  ex_stage_md #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  fa, fb;
    logic [31:0] rd1, rd2, resw, alum, ext, instr;
    logic        alusrc;
    logic [2:0]  op;
    logic [1:0]  rdst;
    logic [4:0]  rs, rt, rd;
    logic [31:0] e_out, e_wd;
    logic [4:0]  e_wr;
  } vec_t;

  typedef struct {
    logic [31:0] hi, lo;
  } hilo_t;

  vec_t  vecs[10];
  hilo_t sb_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.instr_E = '0; bus.RD1 = '0; bus.RD2 = '0; bus.ResultW = '0; bus.ALU_O_M = '0;
    bus.ForwardA_E = 2'b00; bus.ForwardB_E = 2'b00; bus.Rs_E = '0; bus.Rt_E = '0;
    bus.Rd_E = '0; bus.extimm = '0; bus.RegDst_E = 2'b00; bus.ALUSrc_E = 1'b0;
    bus.ALUOp_E = 3'd0; bus.MDOp_E = 3'd0; bus.HiLoRead_E = 2'b00;
  endtask

  task automatic read_hilo(input string name, input logic [31:0] ehi, input logic [31:0] elo);
    bus.HiLoRead_E = 2'b01; #1;
    check({name, "_hi"}, bus.ALUOut, ehi);
    bus.HiLoRead_E = 2'b10; #1;
    check({name, "_lo"}, bus.ALUOut, elo);
    bus.HiLoRead_E = 2'b00; #1;
  endtask

  // Issue one mult/div, count Busy cycles, then pop the expected HI/LO at completion.
  task automatic run_md(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int ncyc, input logic [31:0] ehi,
                        input logic [31:0] elo);
    int    n;
    hilo_t e;
    bus.ForwardA_E = 2'b00; bus.ForwardB_E = 2'b00;
    bus.RD1 = a; bus.RD2 = b; bus.MDOp_E = op; #1;
    check({name, "_stall_at_start"}, bus.Stall_MD, 1'b0);
    sb_q.push_back('{hi: ehi, lo: elo});
    step();
    bus.MDOp_E = 3'd0; #1;
    n = 0;
    while (bus.Busy && n < 200) begin
      n++;
      step();
    end
    check({name, "_busy_cycles"}, n, ncyc);
    if (sb_q.size() == 0) begin
      check({name, "_scoreboard_empty"}, 1, 0);
    end else begin
      e = sb_q.pop_front();
      read_hilo(name, e.hi, e.lo);
    end
  endtask

  initial begin
    int n;
    hilo_t e;
    vecs[0] = '{2'b10, 2'b00, 32'h0, 32'h3, 32'h0, 32'h5, 32'h0, 32'h0, 1'b0, 3'd0, 2'b00,
                5'd1, 5'd7, 5'd2, 32'h8, 32'h3, 5'd7};
    vecs[1] = '{2'b00, 2'b01, 32'd10, 32'h0, 32'd15, 32'h0, 32'h0, 32'h0, 1'b0, 3'd1, 2'b01,
                5'd3, 5'd4, 5'd9, 32'hFFFFFFFB, 32'd15, 5'd9};
    vecs[2] = '{2'b00, 2'b00, 32'hF0F0F0F0, 32'h1234, 32'h0, 32'h0, 32'h0FF00FF0, 32'h0, 1'b1,
                3'd2, 2'b10, 5'd5, 5'd6, 5'd8, 32'h00F000F0, 32'h1234, 5'd31};
    vecs[3] = '{2'b11, 2'b11, 32'hA0000000, 32'h5, 32'h99, 32'h77, 32'h0, 32'h0, 1'b0, 3'd3, 2'b11,
                5'd10, 5'd4, 5'd11, 32'hA0000005, 32'h5, 5'd4};
    vecs[4] = '{2'b00, 2'b00, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 3'd4,
                2'b00, 5'd12, 5'd13, 5'd14, 32'hF0F00F0F, 32'h0F0F0F0F, 5'd13};
    vecs[5] = '{2'b00, 2'b00, 32'h12345678, 32'h80000001, 32'h0, 32'h0, 32'h0, 32'h00000100, 1'b0,
                3'd5, 2'b00, 5'd0, 5'd15, 5'd0, 32'h00000010, 32'h80000001, 5'd15};
    vecs[6] = '{2'b00, 2'b00, 32'h0, 32'h80000000, 32'h0, 32'h0, 32'h0, 32'h000007C0, 1'b0, 3'd6,
                2'b00, 5'd0, 5'd16, 5'd0, 32'h00000001, 32'h80000000, 5'd16};
    vecs[7] = '{2'b00, 2'b00, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 3'd7, 2'b01,
                5'd17, 5'd18, 5'd19, 32'h1, 32'h1, 5'd19};
    vecs[8] = '{2'b00, 2'b00, 32'h5, 32'hFFFFFFFE, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 3'd7, 2'b10,
                5'd20, 5'd21, 5'd22, 32'h0, 32'hFFFFFFFE, 5'd31};
    vecs[9] = '{2'b00, 2'b10, 32'h0, 32'h0, 32'h0, 32'h1234, 32'h0, 32'hFFFFF83F, 1'b0, 3'd6,
                2'b00, 5'd23, 5'd24, 5'd25, 32'h1234, 32'h1234, 5'd24};

    idle();
    reset = 1'b1;
    step(); step();
    reset = 1'b0; #1;
    check("reset_busy", bus.Busy, 1'b0);
    check("reset_stall", bus.Stall_MD, 1'b0);
    read_hilo("reset", 32'h0, 32'h0);

    foreach (vecs[i]) begin
      bus.ForwardA_E = vecs[i].fa; bus.ForwardB_E = vecs[i].fb;
      bus.RD1 = vecs[i].rd1; bus.RD2 = vecs[i].rd2; bus.ResultW = vecs[i].resw;
      bus.ALU_O_M = vecs[i].alum; bus.extimm = vecs[i].ext; bus.instr_E = vecs[i].instr;
      bus.ALUSrc_E = vecs[i].alusrc; bus.ALUOp_E = vecs[i].op; bus.RegDst_E = vecs[i].rdst;
      bus.Rs_E = vecs[i].rs; bus.Rt_E = vecs[i].rt; bus.Rd_E = vecs[i].rd;
      #1;
      check($sformatf("vec%0d_aluout", i), bus.ALUOut, vecs[i].e_out);
      check($sformatf("vec%0d_wdata", i), bus.WriteData_E, vecs[i].e_wd);
      check($sformatf("vec%0d_wreg", i), bus.WriteReg_E, vecs[i].e_wr);
      check($sformatf("vec%0d_rs_haz", i), bus.Rs_Hazard, vecs[i].rs);
      check($sformatf("vec%0d_rt_haz", i), bus.Rt_Hazard, vecs[i].rt);
      check($sformatf("vec%0d_stall", i), bus.Stall_MD, 1'b0);
    end
    idle(); #1;

`ifdef EX_OVERFLOW_EN
    bus.RD1 = 32'h7FFFFFFF; bus.RD2 = 32'h1; bus.ALUOp_E = 3'd0; #1;
    check("ov_add_pos", bus.Ov_E, 1'b1);
    bus.HiLoRead_E = 2'b01; #1;
    check("ov_masked_hi", bus.Ov_E, 1'b0);
    bus.HiLoRead_E = 2'b00;
    bus.RD1 = 32'h80000000; bus.RD2 = 32'h1; bus.ALUOp_E = 3'd1; #1;
    check("ov_sub_neg", bus.Ov_E, 1'b1);
    bus.RD1 = 32'h1; bus.RD2 = 32'h1; bus.ALUOp_E = 3'd0; #1;
    check("ov_add_none", bus.Ov_E, 1'b0);
    idle(); #1;
`endif

    run_md("mult",  3'd1, 32'hFFFFFFFF, 32'h2, 5, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_md("multu", 3'd2, 32'hFFFFFFFF, 32'h2, 5, 32'h00000001, 32'hFFFFFFFE);
    run_md("multu_max", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFE, 32'h00000001);
    run_md("div",   3'd3, 32'hFFFFFFF9, 32'h2, 32, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_md("div_negb", 3'd3, 32'h7, 32'hFFFFFFFE, 32, 32'h00000001, 32'hFFFFFFFD);
    run_md("divu0", 3'd4, 32'h7, 32'h0, 32, 32'h00000007, 32'hFFFFFFFF);
    run_md("div0",  3'd3, 32'h7, 32'h0, 32, 32'h00000007, 32'hFFFFFFFF);
    run_md("div_minneg", 3'd3, 32'h80000000, 32'hFFFFFFFF, 32, 32'h0, 32'h80000000);
    run_md("divu",  3'd4, 32'd100, 32'd7, 32, 32'd2, 32'd14);

    // mflo behind a divide stalls until Busy falls, then reads the fresh quotient.
    bus.RD1 = 32'hFFFFFFF9; bus.RD2 = 32'h2; bus.MDOp_E = 3'd3; #1;
    sb_q.push_back('{hi: 32'hFFFFFFFF, lo: 32'hFFFFFFFD});
    step();
    bus.MDOp_E = 3'd0; #1;
    check("mflo_busy_rise", bus.Busy, 1'b1);
    step();
    bus.HiLoRead_E = 2'b10; #1;
    n = 0;
    while (bus.Stall_MD && n < 100) begin
      n++;
      step();
    end
    check("mflo_stall_cycles", n, 31);
    check("mflo_busy_fell", bus.Busy, 1'b0);
    e = sb_q.pop_front();
    check("mflo_value", bus.ALUOut, e.lo);
    bus.HiLoRead_E = 2'b01; #1;
    check("mfhi_value", bus.ALUOut, e.hi);
    idle(); #1;

    // mthi issued while a mult runs: stalls, is ignored, then executes once free.
    bus.RD1 = 32'd3; bus.RD2 = 32'd4; bus.MDOp_E = 3'd1; #1;
    step();
    bus.MDOp_E = 3'd5; bus.RD1 = 32'h0000DEAD; #1;
    check("mthi_busy_stall", bus.Stall_MD, 1'b1);
    n = 0;
    while (bus.Busy && n < 100) begin
      n++;
      step();
    end
    check("mthi_busy_cycles", n, 5);
    check("mthi_stall_release", bus.Stall_MD, 1'b0);
    bus.HiLoRead_E = 2'b01; #1;
    check("mthi_ignored_hi", bus.ALUOut, 32'h0);
    bus.HiLoRead_E = 2'b10; #1;
    check("mult_small_lo", bus.ALUOut, 32'd12);
    step();
    bus.MDOp_E = 3'd0; bus.HiLoRead_E = 2'b01; #1;
    check("mthi_applied", bus.ALUOut, 32'h0000DEAD);
    idle(); #1;

    // Reset during a divide discards it and clears HI/LO.
    bus.RD1 = 32'd100; bus.RD2 = 32'd7; bus.MDOp_E = 3'd3; #1;
    step();
    bus.MDOp_E = 3'd0;
    for (int k = 0; k < 9; k++) step();
    check("rst_mid_busy_before", bus.Busy, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0; #1;
    check("rst_mid_busy", bus.Busy, 1'b0);
    read_hilo("rst_mid", 32'h0, 32'h0);
    for (int k = 0; k < 30; k++) step();
    check("rst_mid_still_idle", bus.Busy, 1'b0);
    read_hilo("rst_mid_discard", 32'h0, 32'h0);
    bus.ForwardA_E = 2'b01; bus.ResultW = 32'h1234; bus.MDOp_E = 3'd6; #1;
    check("mtlo_no_stall", bus.Stall_MD, 1'b0);
    step();
    bus.MDOp_E = 3'd0; bus.HiLoRead_E = 2'b10; #1;
    check("mtlo_value", bus.ALUOut, 32'h1234);
    check("mtlo_busy", bus.Busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_stage_md.md
Name: ex_stage_md

Overview:
- Parametrised next-generation execute stage for the 5-stage pipeline.
- Combinational datapath: operand forwarding, immediate select, ALU and destination-register select, now at WIDTH bits.
- Adds an iterative multiply/divide unit with architectural HI/LO registers and a busy/stall handshake to the hazard unit.
- Sits between the ID/EX and EX/MEM pipeline registers; ALUOut and WriteData_E feed EX/MEM.

Parameters:
WIDTH, 32, datapath width; must be even and >= 8
MUL_CYCLES, 5, cycles Busy is held for mult/multu (>= 1)
DIV_CYCLES, 32, cycles Busy is held for div/divu (>= 1)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
instr_E  input  32  instruction in EX; shamt = instr_E[10:6]
RD1, RD2  input  WIDTH  register-file read data
ResultW  input  WIDTH  writeback-stage result (forward source)
ALU_O_M  input  WIDTH  memory-stage ALU result (forward source)
ForwardA_E, ForwardB_E  input  2  00 = RDx, 01 = ResultW, 10 = ALU_O_M, 11 = RDx
Rs_E, Rt_E, Rd_E  input  5  register specifiers
extimm  input  WIDTH  extended immediate
RegDst_E  input  2  00 = Rt, 01 = Rd, 10 = 5'd31, 11 = Rt
ALUSrc_E  input  1  1 = extimm on ALU B input
ALUOp_E  input  3  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 slt (signed)
MDOp_E  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
HiLoRead_E  input  2  00 ALU, 01 HI, 10 LO, 11 ALU; selects the ALUOut source
ALUOut  output  WIDTH  ALU result, or HI/LO value per HiLoRead_E
WriteData_E  output  WIDTH  forwarded B operand (before the immediate mux)
WriteReg_E  output  5  destination register
Rs_Hazard, Rt_Hazard  output  5  pass-through of Rs_E, Rt_E
Busy  output  1  multiply/divide unit iterating
Stall_MD  output  1  Busy && (MDOp_E in 1..6 || HiLoRead_E in {01,10})

Behaviour:
- Forwarding, immediate select, ALU and RegDst select are purely combinational; zero latency.
- Shifts use a shamt zero-extended to log2(WIDTH) bits. slt result = {WIDTH-1 zeros, signed(A) < signed(B)}.
- md_start = MDOp_E in 1..4 && !Busy. Operands come from the forwarded A and the forwarded B values. The ALUSrc mux is not applied.
- On md_start:
  - Operands are latched; Busy = 1 from the next cycle.
  - Counter loads MUL_CYCLES or DIV_CYCLES. It decrements every cycle; when it reaches 1, the next edge writes HI/LO and clears Busy.
  - Total occupancy is exactly N cycles; HI/LO is visible on the cycle Busy falls.
- Multiply: {HI,LO} = 2*WIDTH-bit product; signed for op 1, unsigned for op 2.
- Divide: LO = quotient, HI = remainder. Truncates toward zero; remainder takes the sign of the dividend (op 3).
  - Divisor 0: LO = all ones, HI = dividend.
  - Signed most-negative / -1: LO = most-negative, HI = 0.
- mthi/mtlo when !Busy: HI or LO = forwarded A on the next edge. When Busy, the write is ignored and Stall_MD is asserted.
- Any MD op, or any HI/LO read, while Busy raises Stall_MD. The hazard unit freezes EX, so the instruction re-presents and executes once Busy is 0. md_start is never accepted while Busy.
- An HI/LO read with Busy = 0 returns the current registers. A write that completes on the same edge is visible the next cycle.
- Reset has priority over all activity, including mid-iteration:
  - Busy = 0, counter = 0, HI = LO = 0, latched operands = 0.
  - Any in-flight result is discarded.

Optional Feature:
- Macro EX_OVERFLOW_EN.
- When defined:
  - Extra output Ov_E (1 bit) = signed overflow of add (ALUOp 0) or sub (ALUOp 1): operand signs equal and result sign differs (add); signs differ and result sign differs from A (sub).
  - Ov_E = 0 for all other ops and when HiLoRead_E selects HI/LO.
- When undefined: port absent; no overflow logic.

Test Plan:
- WIDTH=32, ForwardA_E=10, ALU_O_M=0x00000005, RD2=3, ALUOp add, ALUSrc_E=0 -> ALUOut=8, WriteData_E=3, Stall_MD=0.
- mult A=0xFFFFFFFF (-1), B=2 -> Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu same operands -> HI=1, LO=0xFFFFFFFE.
- div A=-7, B=2 -> after 32 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/0 -> LO=0xFFFFFFFF, HI=7.
- mflo (HiLoRead_E=10) presented 1 cycle after a div start -> Stall_MD=1 for 31 cycles; it then reads the quotient on the cycle Busy falls.
- reset asserted at cycle 10 of a divide -> next cycle Busy=0, HI=LO=0; mtlo 0x1234 afterwards -> LO=0x1234.
- EX_OVERFLOW_EN: add 0x7FFFFFFF+1 -> Ov_E=1; sub 0x80000000-1 -> Ov_E=1; add 1+1 -> Ov_E=0.
